// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state types shared by the AXI4-Lite register file
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axi_lite_addr_dec.sv
// axi_lite_addr_dec: byte address -> register index plus error flag (misaligned or past the last register)
//   i_addr  byte address
//   o_idx   word index addr[IDX_W+1:2]
//   o_err   1 when addr[1:0]!=0 or addr >= 4*NUM_REGS
module axi_lite_addr_dec #(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_err
);
  assign o_idx = i_addr[IDX_W+1:2];
  // NUM_REGS is a power of two, so any bit above the index field means out of range
  assign o_err = (i_addr[1:0] != 2'b00) || ((i_addr >> (IDX_W + 2)) != '0);
endmodule

// File: rtl/axi_lite_slv_regfile.sv
// axi_lite_slv_regfile: AXI4-Lite slave terminating in a register file, reg 0 is a read-only ID
//   aclk/areset            clock, asynchronous active-high reset
//   aw*/w*/b*              write address, write data (byte strobes), write response
//   ar*/r*                 read address, read data/response
//   All outputs come from registers; one outstanding transaction per direction.
module axi_lite_slv_regfile
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hA5A5_0001,
  localparam int               IDX_W    = $clog2(NUM_REGS),
  localparam int               STRB_W   = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready
);
  wr_state_t         r_wst, w_wst_nxt;
  rd_state_t         r_rst, w_rst_nxt;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  resp_t             r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic [IDX_W-1:0]  w_widx, w_ridx;
  logic              w_werr, w_rerr, w_commit;
  logic [DATA_W-1:0] w_rd_val;
  assign awready = (r_wst == W_IDLE) || (r_wst == W_HAVE_W);
  assign wready  = (r_wst == W_IDLE) || (r_wst == W_HAVE_AW);
  assign bvalid  = (r_wst == W_RESP);
  assign bresp   = r_bresp;
  assign arready = (r_rst == R_IDLE);
  assign rvalid  = (r_rst == R_DATA);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  // Whichever half arrived first was parked; the other half is taken straight from the bus
  assign w_waddr = (r_wst == W_HAVE_AW) ? r_awaddr : awaddr;
  assign w_wdata = (r_wst == W_HAVE_W) ? r_wdata : wdata;
  assign w_wstrb = (r_wst == W_HAVE_W) ? r_wstrb : wstrb;
  axi_lite_addr_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wdec (
    .i_addr (w_waddr),
    .o_idx  (w_widx),
    .o_err  (w_werr)
  );
  axi_lite_addr_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rdec (
    .i_addr (araddr),
    .o_idx  (w_ridx),
    .o_err  (w_rerr)
  );
  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE:    w_wst_nxt = (awvalid && wvalid) ? W_RESP :
                             awvalid ? W_HAVE_AW : wvalid ? W_HAVE_W : W_IDLE;
      W_HAVE_AW: w_wst_nxt = wvalid ? W_RESP : W_HAVE_AW;
      W_HAVE_W:  w_wst_nxt = awvalid ? W_RESP : W_HAVE_W;
      W_RESP:    w_wst_nxt = bready ? W_IDLE : W_RESP;
      default:   w_wst_nxt = W_IDLE;
    endcase
  end
  // Both halves are present exactly on the cycle the FSM moves into RESP
  assign w_commit = (r_wst != W_RESP) && (w_wst_nxt == W_RESP);
  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE:  w_rst_nxt = arvalid ? R_DATA : R_IDLE;
      R_DATA:  w_rst_nxt = rready ? R_IDLE : R_DATA;
      default: w_rst_nxt = R_IDLE;
    endcase
  end
  assign w_rd_val = (w_ridx == '0) ? ID_VALUE : r_regs[w_ridx];
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wst    <= W_IDLE;
      r_rst    <= R_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= OKAY;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
      if (awvalid && awready) r_awaddr <= awaddr;
      if (wvalid && wready) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_werr ? SLVERR : OKAY;
      // Sampled before this edge's register update, so a colliding write is not visible yet
      if (arvalid && arready) begin
        r_rdata <= w_rerr ? '0 : w_rd_val;
        r_rresp <= w_rerr ? SLVERR : OKAY;
      end
    end
  end
  // Slot 0 stays zero; the ID constant is muxed in on reads
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && !w_werr && (w_widx != '0)) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_wstrb[b]) r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_axi_lite_slv_regfile.sv
// tb_axi_lite_slv_regfile: directed stimulus with queued expected responses checked by a monitor
module tb_axi_lite_slv_regfile;
  logic        aclk = 0;
  logic        areset = 1;
  logic [11:0] awaddr = 0;
  logic        awvalid = 0;
  logic        awready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wvalid = 0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1;
  logic [11:0] araddr = 0;
  logic        arvalid = 0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  axi_lite_slv_regfile dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_unexpected: got bresp %b with nothing expected", bresp);
        end else chk("bresp", {62'd0, bresp}, {62'd0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_unexpected: got rdata %h rresp %b with nothing expected", rdata, rresp);
        end else chk("rdata_rresp", {30'd0, rdata, rresp}, {30'd0, rq.pop_front()});
      end
    end
  endtask
  task automatic send_aw(input logic [11:0] a);
    bit ok = 0;
    awaddr = a;
    awvalid = 1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge aclk);
      ok = awready;
      step();
    end
    awvalid = 0;
    chk("aw_handshake", {63'd0, ok}, 64'd1);
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge aclk);
      ok = wready;
      step();
    end
    wvalid = 0;
    chk("w_handshake", {63'd0, ok}, 64'd1);
  endtask
  task automatic send_ar(input logic [11:0] a);
    bit ok = 0;
    araddr = a;
    arvalid = 1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge aclk);
      ok = arready;
      step();
    end
    arvalid = 0;
    chk("ar_handshake", {63'd0, ok}, 64'd1);
  endtask
  // gap 0: AW and W together; gap>0: AW then W after gap cycles; gap<0: W first
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int gap, input logic [1:0] exp);
    bq.push_back(exp);
    if (gap == 0) begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end else if (gap > 0) begin
      send_aw(a);
      repeat (gap) step();
      send_w(d, s);
    end else begin
      send_w(d, s);
      repeat (-gap) step();
      send_aw(a);
    end
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] exp);
    rq.push_back({d, exp});
    send_ar(a);
  endtask
  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain", {32'd0, 16'(bq.size()), 16'(rq.size())}, 64'd0);
  endtask
  task automatic chk_reset_outputs(input string name);
    @(negedge aclk);
    chk(name, {25'd0, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata},
        {25'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0});
  endtask
  initial begin
    fork
      monitor();
    join_none
    repeat (2) step();
    chk_reset_outputs("reset_outputs");
    step();
    areset = 0;
    step();
    rd(12'h000, 32'hA5A5_0001, 2'b00);
    rd(12'h004, 32'h0, 2'b00);
    drain();
    wr(12'h008, 32'hDEAD_BEEF, 4'hF, 2, 2'b00);
    drain();
    rd(12'h008, 32'hDEAD_BEEF, 2'b00);
    drain();
    send_w(32'h1122_3344, 4'b0101);
    @(negedge aclk);
    chk("have_w_wready", {63'd0, wready}, 64'd0);
    step();
    bq.push_back(2'b00);
    send_aw(12'h00C);
    drain();
    rd(12'h00C, 32'h0022_0044, 2'b00);
    drain();
    wr(12'h040, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
    rd(12'h040, 32'h0, 2'b10);
    drain();
    wr(12'h006, 32'hFFFF_FFFF, 4'hF, 1, 2'b10);
    rd(12'h006, 32'h0, 2'b10);
    drain();
    rd(12'h004, 32'h0, 2'b00);
    rd(12'h000, 32'hA5A5_0001, 2'b00);
    drain();
    wr(12'h000, 32'h1234_5678, 4'hF, 0, 2'b00);
    drain();
    rd(12'h000, 32'hA5A5_0001, 2'b00);
    drain();
    bready = 0;
    wr(12'h010, 32'h0BAD_F00D, 4'hF, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("b_stall", {60'd0, bvalid, bresp, awready | wready}, {60'd0, 1'b1, 2'b00, 1'b0});
      step();
    end
    bready = 1;
    drain();
    rready = 0;
    rd(12'h010, 32'h0BAD_F00D, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("r_stall", {27'd0, rvalid, rdata, rresp, arready}, {27'd0, 1'b1, 32'h0BAD_F00D, 2'b00, 1'b0});
      step();
    end
    rready = 1;
    drain();
    rq.push_back({32'h0BAD_F00D, 2'b00});
    fork
      wr(12'h010, 32'h1234_5678, 4'hF, 0, 2'b00);
      send_ar(12'h010);
    join
    drain();
    rd(12'h010, 32'h1234_5678, 2'b00);
    drain();
    send_aw(12'h014);
    @(negedge aclk);
    chk("have_aw_awready", {63'd0, awready}, 64'd0);
    areset = 1;
    chk_reset_outputs("mid_burst_reset");
    step();
    areset = 0;
    step();
    rd(12'h008, 32'h0, 2'b00);
    drain();
    wr(12'h014, 32'hCAFE_0000, 4'hF, 1, 2'b00);
    drain();
    rd(12'h014, 32'hCAFE_0000, 2'b00);
    drain();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
